// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings for the writeback path: result sources, load funct3
// codes, load error codes, and the writeback FSM state type.
package riscv_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_NONE = 2'd3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_RSP = 1'b1
    } wb_state_t;

    function automatic logic load_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if ((f3 == F3_LH) || (f3 == F3_LHU)) mis = off[0];
        else if (f3 == F3_LW)                 mis = (off != 2'd0);
        return mis;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Upstream instruction issue bundle into the writeback unit.
// Handshake: an instruction transfers on a rising clk edge where in_valid and
// in_ready are both high; the payload fields are only meaningful with in_valid.
interface writeback_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wb_sel;
    logic        rd_we_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [2:0]  ld_funct3;

    modport master (
        output in_valid, wb_sel, rd_we_in, rd_addr_in, alu_result, pc_plus4, ld_funct3,
        input  in_ready
    );

    modport slave (
        input  in_valid, wb_sel, rd_we_in, rd_addr_in, alu_result, pc_plus4, ld_funct3,
        output in_ready
    );
endinterface

// File: rtl/load_align.sv
// Picks the byte/half at the load offset out of an aligned memory word and
// sign- or zero-extends it according to the load funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];

        data = word;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: registers ALU/PC4 results in one cycle, waits for data
// memory on loads, and reports misaligned, illegal and timed-out loads.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    writeback_unit_if.slave   up,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              wr_en,
    output logic [4:0]        rd_addr,
    output logic [31:0]       rd_data,
    output logic              retire,
    output logic              ld_err,
    output logic [1:0]        ld_err_code,
    output wb_state_t         state_dbg
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cap_we, cap_we_nxt;
    logic [4:0]       cap_rd, cap_rd_nxt;
    logic [2:0]       cap_funct3, cap_funct3_nxt;
    logic [1:0]       cap_off, cap_off_nxt;

    logic             wr_en_nxt, retire_nxt, ld_err_nxt;
    logic [1:0]       ld_err_code_nxt;
    logic [4:0]       rd_addr_nxt;
    logic [31:0]      rd_data_nxt;
    logic [31:0]      load_data;
    logic             alu_we;
    logic             load_we;

    load_align u_load_align (
        .word   (mem_rsp_data),
        .offset (cap_off),
        .funct3 (cap_funct3),
        .data   (load_data)
    );

    assign up.in_ready = (state == ST_IDLE) && !rst;
    assign state_dbg   = state;

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        cap_we_nxt      = cap_we;
        cap_rd_nxt      = cap_rd;
        cap_funct3_nxt  = cap_funct3;
        cap_off_nxt     = cap_off;
        wr_en_nxt       = 1'b0;
        retire_nxt      = 1'b0;
        ld_err_nxt      = 1'b0;
        ld_err_code_nxt = ld_err_code;
        rd_addr_nxt     = rd_addr;
        rd_data_nxt     = rd_data;
        alu_we  = up.rd_we_in && (up.rd_addr_in != 5'd0) && (up.wb_sel != WB_NONE);
        load_we = cap_we && (cap_rd != 5'd0);

        case (state)
            ST_IDLE: begin
                if (up.in_valid) begin
                    if (up.wb_sel == WB_LOAD) begin
                        if (!load_legal(up.ld_funct3)) begin
                            ld_err_nxt      = 1'b1;
                            ld_err_code_nxt = ERR_ILLEGAL;
                        end else if (load_misaligned(up.ld_funct3, up.alu_result[1:0])) begin
                            ld_err_nxt      = 1'b1;
                            ld_err_code_nxt = ERR_MISALIGN;
                        end else begin
                            cap_we_nxt     = up.rd_we_in;
                            cap_rd_nxt     = up.rd_addr_in;
                            cap_funct3_nxt = up.ld_funct3;
                            cap_off_nxt    = up.alu_result[1:0];
                            cnt_nxt        = '0;
                            state_nxt      = ST_WAIT_RSP;
                        end
                    end else begin
                        // Reserved wb_sel still retires, it just never writes.
                        retire_nxt = 1'b1;
                        wr_en_nxt  = alu_we;
                        if (alu_we) begin
                            rd_addr_nxt = up.rd_addr_in;
                            rd_data_nxt = (up.wb_sel == WB_PC4) ? up.pc_plus4 : up.alu_result;
                        end
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    retire_nxt = 1'b1;
                    wr_en_nxt  = load_we;
                    if (load_we) begin
                        rd_addr_nxt = cap_rd;
                        rd_data_nxt = load_data;
                    end
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    ld_err_nxt      = 1'b1;
                    ld_err_code_nxt = ERR_TIMEOUT;
                    cnt_nxt         = '0;
                    state_nxt       = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cap_we      <= 1'b0;
            cap_rd      <= 5'd0;
            cap_funct3  <= 3'd0;
            cap_off     <= 2'd0;
            wr_en       <= 1'b0;
            retire      <= 1'b0;
            ld_err      <= 1'b0;
            ld_err_code <= ERR_NONE;
            rd_addr     <= 5'd0;
            rd_data     <= 32'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cap_we      <= cap_we_nxt;
            cap_rd      <= cap_rd_nxt;
            cap_funct3  <= cap_funct3_nxt;
            cap_off     <= cap_off_nxt;
            wr_en       <= wr_en_nxt;
            retire      <= retire_nxt;
            ld_err      <= ld_err_nxt;
            ld_err_code <= ld_err_code_nxt;
            rd_addr     <= rd_addr_nxt;
            rd_data     <= rd_data_nxt;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU/PC4 writes, load extraction, load
// errors, timeout, and reset during an outstanding load.
module tb_writeback_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        retire;
    logic        ld_err;
    logic [1:0]  ld_err_code;
    wb_state_t   state_dbg;

    int checks;
    int failures;

    writeback_unit_if up_if ();

    writeback_unit #(.TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .up            (up_if),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .wr_en         (wr_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .retire        (retire),
        .ld_err        (ld_err),
        .ld_err_code   (ld_err_code),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; outputs are sampled after it.
    task automatic issue(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
        up_if.in_valid   = 1'b1;
        up_if.wb_sel     = sel;
        up_if.rd_we_in   = we;
        up_if.rd_addr_in = rd;
        up_if.alu_result = alu;
        up_if.pc_plus4   = pc4;
        up_if.ld_funct3  = f3;
        tick();
        up_if.in_valid   = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (up_if.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", up_if.in_ready); end
        checks++; if (wr_en !== 1'b0 || retire !== 1'b0 || ld_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%0b%0b%0b exp=000", wr_en, retire, ld_err); end
        checks++; if (rd_addr !== 5'd0 || rd_data !== 32'd0 || ld_err_code !== 2'd0) begin failures++; $display("FAIL reset_regs got=%0h/%0h/%0h exp=0/0/0", rd_addr, rd_data, ld_err_code); end
        checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        rst = 1'b0;
        #1;
        checks++; if (up_if.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", up_if.in_ready); end
    endtask

    task automatic test_alu();
        issue(WB_ALU, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 3'd0);
        checks++; if (wr_en !== 1'b1 || retire !== 1'b1) begin failures++; $display("FAIL alu_pulse got=%0b%0b exp=11", wr_en, retire); end
        checks++; if (rd_addr !== 5'd5 || rd_data !== 32'h0000_1234) begin failures++; $display("FAIL alu_data got=%0d:%08h exp=5:00001234", rd_addr, rd_data); end
        checks++; if (up_if.in_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%0b exp=1", up_if.in_ready); end
        tick();
        checks++; if (wr_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL alu_pulse_end got=%0b%0b exp=00", wr_en, retire); end
        checks++; if (rd_data !== 32'h0000_1234) begin failures++; $display("FAIL alu_hold got=%08h exp=00001234", rd_data); end
    endtask

    task automatic test_pc4_and_nowrite();
        issue(WB_PC4, 1'b1, 5'd1, 32'hDEAD_BEEF, 32'h0000_0100, 3'd0);
        checks++; if (wr_en !== 1'b1 || rd_addr !== 5'd1 || rd_data !== 32'h0000_0100) begin failures++; $display("FAIL pc4_write got=%0b:%0d:%08h exp=1:1:00000100", wr_en, rd_addr, rd_data); end
        issue(WB_ALU, 1'b1, 5'd0, 32'h5555_5555, 32'h0, 3'd0);
        checks++; if (wr_en !== 1'b0 || retire !== 1'b1 || rd_data !== 32'h0000_0100) begin failures++; $display("FAIL x0_write got=%0b:%0b:%08h exp=0:1:00000100", wr_en, retire, rd_data); end
        issue(WB_NONE, 1'b1, 5'd9, 32'h7777_7777, 32'h0, 3'd0);
        checks++; if (wr_en !== 1'b0 || retire !== 1'b1 || rd_addr !== 5'd1) begin failures++; $display("FAIL reserved_sel got=%0b:%0b:%0d exp=0:1:1", wr_en, retire, rd_addr); end
        issue(WB_ALU, 1'b0, 5'd9, 32'h7777_7777, 32'h0, 3'd0);
        checks++; if (wr_en !== 1'b0 || retire !== 1'b1) begin failures++; $display("FAIL no_we got=%0b:%0b exp=0:1", wr_en, retire); end
    endtask

    task automatic test_back_to_back();
        up_if.in_valid   = 1'b1;
        up_if.wb_sel     = WB_ALU;
        up_if.rd_we_in   = 1'b1;
        up_if.rd_addr_in = 5'd10;
        up_if.alu_result = 32'hAAAA_0001;
        tick();
        checks++; if (wr_en !== 1'b1 || rd_addr !== 5'd10 || rd_data !== 32'hAAAA_0001) begin failures++; $display("FAIL b2b_first got=%0b:%0d:%08h exp=1:10:aaaa0001", wr_en, rd_addr, rd_data); end
        up_if.rd_addr_in = 5'd11;
        up_if.alu_result = 32'hBBBB_0002;
        tick();
        up_if.in_valid = 1'b0;
        checks++; if (wr_en !== 1'b1 || retire !== 1'b1 || rd_addr !== 5'd11 || rd_data !== 32'hBBBB_0002) begin failures++; $display("FAIL b2b_second got=%0b:%0b:%0d:%08h exp=1:1:11:bbbb0002", wr_en, retire, rd_addr, rd_data); end
        tick();
    endtask

    task automatic test_lb_sign();
        int low_cycles;
        low_cycles = 0;
        issue(WB_LOAD, 1'b1, 5'd7, 32'h0000_1003, 32'h0, F3_LB);
        checks++; if (state_dbg !== ST_WAIT_RSP || wr_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL lb_enter_wait got=%0d:%0b:%0b exp=1:0:0", state_dbg, wr_en, retire); end
        if (up_if.in_ready === 1'b0) low_cycles++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (up_if.in_ready === 1'b0) low_cycles++;
        end
        respond(32'h80FF_FF7F);
        if (up_if.in_ready === 1'b0) low_cycles++;
        checks++; if (wr_en !== 1'b1 || retire !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_sign got=%0b:%0b:%0d:%08h exp=1:1:7:ffffff80", wr_en, retire, rd_addr, rd_data); end
        checks++; if (low_cycles !== 4) begin failures++; $display("FAIL lb_ready_low got=%0d exp=4", low_cycles); end
        checks++; if (up_if.in_ready !== 1'b1) begin failures++; $display("FAIL lb_ready_back got=%0b exp=1", up_if.in_ready); end
        tick();
        checks++; if (wr_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL lb_pulse_end got=%0b%0b exp=00", wr_en, retire); end
    endtask

    task automatic test_load_formats();
        issue(WB_LOAD, 1'b1, 5'd8, 32'h0000_2002, 32'h0, F3_LHU);
        respond(32'h9ABC_1234);
        checks++; if (wr_en !== 1'b1 || rd_data !== 32'h0000_9ABC) begin failures++; $display("FAIL lhu got=%0b:%08h exp=1:00009abc", wr_en, rd_data); end
        issue(WB_LOAD, 1'b1, 5'd8, 32'h0000_2000, 32'h0, F3_LH);
        respond(32'h1111_8001);
        checks++; if (rd_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_sign got=%08h exp=ffff8001", rd_data); end
        issue(WB_LOAD, 1'b1, 5'd8, 32'h0000_2001, 32'h0, F3_LBU);
        respond(32'h0000_A500);
        checks++; if (rd_data !== 32'h0000_00A5) begin failures++; $display("FAIL lbu got=%08h exp=000000a5", rd_data); end
        issue(WB_LOAD, 1'b1, 5'd12, 32'h0000_2004, 32'h0, F3_LW);
        respond(32'hCAFE_F00D);
        checks++; if (rd_addr !== 5'd12 || rd_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL lw got=%0d:%08h exp=12:cafef00d", rd_addr, rd_data); end
        issue(WB_LOAD, 1'b1, 5'd0, 32'h0000_2004, 32'h0, F3_LW);
        checks++; if (up_if.in_ready !== 1'b0) begin failures++; $display("FAIL ld_x0_wait got=%0b exp=0", up_if.in_ready); end
        respond(32'h1234_5678);
        checks++; if (wr_en !== 1'b0 || retire !== 1'b1 || rd_data !== 32'hCAFE_F00D) begin failures++; $display("FAIL ld_x0 got=%0b:%0b:%08h exp=0:1:cafef00d", wr_en, retire, rd_data); end
    endtask

    task automatic test_load_errors();
        issue(WB_LOAD, 1'b1, 5'd3, 32'h0000_3001, 32'h0, F3_LW);
        checks++; if (ld_err !== 1'b1 || ld_err_code !== ERR_MISALIGN) begin failures++; $display("FAIL lw_misalign got=%0b:%0d exp=1:1", ld_err, ld_err_code); end
        checks++; if (wr_en !== 1'b0 || retire !== 1'b0 || up_if.in_ready !== 1'b1) begin failures++; $display("FAIL lw_misalign_side got=%0b:%0b:%0b exp=0:0:1", wr_en, retire, up_if.in_ready); end
        tick();
        checks++; if (ld_err !== 1'b0) begin failures++; $display("FAIL err_pulse_end got=%0b exp=0", ld_err); end
        issue(WB_LOAD, 1'b1, 5'd3, 32'h0000_3003, 32'h0, F3_LH);
        checks++; if (ld_err !== 1'b1 || ld_err_code !== ERR_MISALIGN || state_dbg !== ST_IDLE) begin failures++; $display("FAIL lh_misalign got=%0b:%0d:%0d exp=1:1:0", ld_err, ld_err_code, state_dbg); end
        issue(WB_LOAD, 1'b1, 5'd3, 32'h0000_3000, 32'h0, 3'd6);
        checks++; if (ld_err !== 1'b1 || ld_err_code !== ERR_ILLEGAL || wr_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL illegal_f3 got=%0b:%0d:%0b:%0b exp=1:3:0:0", ld_err, ld_err_code, wr_en, retire); end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hFFFF_FFFF;
        tick();
        tick();
        mem_rsp_valid = 1'b0;
        checks++; if (wr_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL idle_rsp_ignored got=%0b%0b exp=00", wr_en, retire); end
    endtask

    task automatic test_timeout();
        int seen_at;
        seen_at = 0;
        issue(WB_LOAD, 1'b1, 5'd4, 32'h0000_4000, 32'h0, F3_LW);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ld_err === 1'b1) begin
                seen_at = i;
                break;
            end
        end
        checks++; if (seen_at !== 8) begin failures++; $display("FAIL timeout_cycles got=%0d exp=8", seen_at); end
        checks++; if (ld_err_code !== ERR_TIMEOUT || wr_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL timeout_code got=%0d:%0b:%0b exp=2:0:0", ld_err_code, wr_en, retire); end
        checks++; if (up_if.in_ready !== 1'b1) begin failures++; $display("FAIL timeout_ready got=%0b exp=1", up_if.in_ready); end
        respond(32'h0BAD_0BAD);
        checks++; if (wr_en !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL late_rsp got=%0b%0b exp=00", wr_en, retire); end
    endtask

    task automatic test_reset_mid_wait();
        issue(WB_LOAD, 1'b1, 5'd6, 32'h0000_5000, 32'h0, F3_LW);
        tick();
        rst = 1'b1;
        tick();
        checks++; if (up_if.in_ready !== 1'b0 || state_dbg !== ST_IDLE) begin failures++; $display("FAIL midrst_held got=%0b:%0d exp=0:0", up_if.in_ready, state_dbg); end
        rst = 1'b0;
        #1;
        checks++; if (up_if.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0b exp=1", up_if.in_ready); end
        respond(32'h1357_9BDF);
        checks++; if (wr_en !== 1'b0 || retire !== 1'b0 || rd_data !== 32'd0) begin failures++; $display("FAIL midrst_rsp got=%0b:%0b:%08h exp=0:0:00000000", wr_en, retire, rd_data); end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        mem_rsp_valid    = 1'b0;
        mem_rsp_data     = 32'd0;
        up_if.in_valid   = 1'b0;
        up_if.wb_sel     = 2'd0;
        up_if.rd_we_in   = 1'b0;
        up_if.rd_addr_in = 5'd0;
        up_if.alu_result = 32'd0;
        up_if.pc_plus4   = 32'd0;
        up_if.ld_funct3  = 3'd0;

        test_reset();
        test_alu();
        test_pc4_and_nowrite();
        test_back_to_back();
        test_lb_sign();
        test_load_formats();
        test_load_errors();
        test_timeout();
        test_reset_mid_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
